// File: rtl/mpu_matrix_loader_if.sv
// Stream-in / matrix-out bus of the 5x5 MPU matrix loader.
// The master drives the element stream and the matrix acknowledge.
// The slave (the loader) returns the ready flag, the completed matrix and the fill level.
interface mpu_matrix_loader_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_data;
    logic               in_col_major;
    logic               clear;
    logic signed [199:0] matrix_out;
    logic               out_valid;
    logic               out_ready;
    logic [4:0]         load_count;

    modport master (
        output in_valid, in_data, in_col_major, clear, out_ready,
        input  in_ready, matrix_out, out_valid, load_count
    );

    modport slave (
        input  in_valid, in_data, in_col_major, clear, out_ready,
        output in_ready, matrix_out, out_valid, load_count
    );
endinterface

// File: rtl/mpu_matrix_loader.sv
// Loads a 5x5 matrix of signed bytes from an element stream, in row-major or
// column-major order, and presents it as one flat 200-bit word once it is complete.
// The write position is kept as row/column counters, so no divide is needed.
// The completed matrix lives in its own register, so a new matrix can load
// behind the one still being presented.
module mpu_matrix_loader (
    input  logic clk,
    input  logic rst_n,
    mpu_matrix_loader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [4:0]     count_r;
    logic [4:0]     count_next_s;
    logic [2:0]     row_r;
    logic [2:0]     row_next_s;
    logic [2:0]     col_r;
    logic [2:0]     col_next_s;
    logic           mode_r;
    logic           mode_next_s;
    logic           out_valid_r;
    logic           out_valid_next_s;
    logic           in_ready_r;
    logic           capture_s;
    logic           hs_s;
    logic [4:0]     idx_s;
    logic [7:0]     off_s;
    logic [199:0]   buf_r;
    logic [199:0]   buf_next_s;
    logic [199:0]   matrix_r;

    // A clear blocks acceptance even when the loader is ready.
    assign hs_s  = bus.in_valid & in_ready_r & ~bus.clear;
    // Element index c + 5*r, with the multiply by 5 done as a shift plus an add.
    assign idx_s = {row_r[2:0], 2'b00} + {2'b00, row_r} + {2'b00, col_r};
    assign off_s = {idx_s, 3'b000};

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.load_count = count_r;
    assign bus.matrix_out = matrix_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state, fill count, write position and output-valid; clear overrides everything else.
    always_comb begin
        state_next_s     = state_r;
        count_next_s     = count_r;
        row_next_s       = row_r;
        col_next_s       = col_r;
        mode_next_s      = mode_r;
        out_valid_next_s = out_valid_r;
        capture_s        = 1'b0;
        if (bus.clear) begin
            state_next_s     = IDLE;
            count_next_s     = 5'd0;
            row_next_s       = 3'd0;
            col_next_s       = 3'd0;
            out_valid_next_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hs_s) begin
                        // The first element fixes the stream order for the whole matrix.
                        state_next_s = LOAD;
                        count_next_s = 5'd1;
                        mode_next_s  = bus.in_col_major;
                        if (bus.in_col_major) begin
                            row_next_s = 3'd1;
                            col_next_s = 3'd0;
                        end else begin
                            row_next_s = 3'd0;
                            col_next_s = 3'd1;
                        end
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                LOAD: begin
                    if (hs_s) begin
                        count_next_s = count_r + 5'd1;
                        if (count_r == 5'd24) begin
                            state_next_s     = FULL;
                            out_valid_next_s = 1'b1;
                            capture_s        = 1'b1;
                            row_next_s       = 3'd0;
                            col_next_s       = 3'd0;
                        end else if (mode_r) begin
                            if (row_r == 3'd4) begin
                                row_next_s = 3'd0;
                                col_next_s = col_r + 3'd1;
                            end else begin
                                row_next_s = row_r + 3'd1;
                            end
                        end else begin
                            if (col_r == 3'd4) begin
                                col_next_s = 3'd0;
                                row_next_s = row_r + 3'd1;
                            end else begin
                                col_next_s = col_r + 3'd1;
                            end
                        end
                    end else begin
                        state_next_s = LOAD;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        state_next_s     = IDLE;
                        count_next_s     = 5'd0;
                        out_valid_next_s = 1'b0;
                    end else begin
                        state_next_s = FULL;
                    end
                end
                default: begin
                    state_next_s     = IDLE;
                    count_next_s     = 5'd0;
                    row_next_s       = 3'd0;
                    col_next_s       = 3'd0;
                    out_valid_next_s = 1'b0;
                end
            endcase
        end
    end

    // Buffer update: the first element of a matrix wipes the stale contents of the buffer.
    always_comb begin
        buf_next_s = buf_r;
        if (hs_s) begin
            if (state_r == IDLE) begin
                buf_next_s = 200'd0;
            end else begin
                buf_next_s = buf_r;
            end
            buf_next_s[off_s +: 8] = bus.in_data;
        end else begin
            buf_next_s = buf_r;
        end
    end

    // Counters, latched order, ready/valid flags, buffer and the presented matrix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= 5'd0;
            row_r       <= 3'd0;
            col_r       <= 3'd0;
            mode_r      <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            buf_r       <= 200'd0;
            matrix_r    <= 200'd0;
        end else begin
            count_r     <= count_next_s;
            row_r       <= row_next_s;
            col_r       <= col_next_s;
            mode_r      <= mode_next_s;
            out_valid_r <= out_valid_next_s;
            in_ready_r  <= (state_next_s != FULL);
            buf_r       <= buf_next_s;
            if (capture_s) begin
                matrix_r <= buf_next_s;
            end else begin
                matrix_r <= matrix_r;
            end
        end
    end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed and randomized bench for mpu_matrix_loader against a reference model
// that holds the matrix as a 5x5 array and places element n with n/5 and n%5.
module tb_mpu_matrix_loader;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mpu_matrix_loader_if bus ();

    mpu_matrix_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic signed [7:0] vals [25];
    byte  m_buf [5][5];
    byte  m_out [5][5];
    int   m_count;
    bit   m_full;
    bit   m_valid;
    bit   m_rdy;
    bit   m_mode;
    bit   hold_en;
    logic [199:0] hold_val;

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [199:0] flat();
        logic [199:0] f;
        f = 200'd0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                f[8*(c+5*r) +: 8] = m_out[r][c];
        return f;
    endfunction

    task automatic check_outputs();
        chk("in_ready",   {199'd0, bus.in_ready},  {199'd0, m_rdy});
        chk("out_valid",  {199'd0, bus.out_valid}, {199'd0, m_valid});
        chk("load_count", {195'd0, bus.load_count}, 200'(m_count));
        chk("matrix_out", bus.matrix_out, flat());
        if (hold_en && !m_valid) chk("hold_A", bus.matrix_out, hold_val);
    endtask

    // One clock cycle: drive inputs, advance the model by the edge, check outputs.
    task automatic cycle(input logic v, input logic cm, input logic clr, input logic ordy);
        logic signed [7:0] d;
        int r;
        int c;
        d = (m_count < 25) ? vals[m_count] : 8'($urandom);
        bus.in_valid = v; bus.in_data = d; bus.in_col_major = cm;
        bus.clear = clr; bus.out_ready = ordy;
        @(posedge clk); #1;
        if (clr) begin
            m_count = 0; m_full = 0; m_valid = 0;
        end else if (m_full) begin
            if (ordy) begin m_full = 0; m_valid = 0; m_count = 0; end
        end else if (v && m_rdy) begin
            if (m_count == 0) begin
                m_mode = cm;
                foreach (m_buf[i, j]) m_buf[i][j] = 8'sd0;
            end
            r = m_mode ? m_count % 5 : m_count / 5;
            c = m_mode ? m_count / 5 : m_count % 5;
            m_buf[r][c] = d;
            m_count++;
            if (m_count == 25) begin m_full = 1; m_valid = 1; m_out = m_buf; end
        end
        m_rdy = !m_full;
        check_outputs();
    endtask

    // Stream elements until the model count reaches target, with a cycle budget.
    task automatic load_to(input int target, input bit rnd_v, input logic cm0, input bit tog_cm);
        int guard;
        logic v;
        logic cm;
        guard = 0;
        while (m_count < target && guard < 400) begin
            v  = rnd_v ? 1'($urandom_range(0, 1)) : 1'b1;
            cm = (m_count == 0 || !tog_cm) ? cm0 : 1'($urandom_range(0, 1));
            cycle(v, cm, 1'b0, 1'b0);
            guard++;
        end
        chk("load_budget", 200'(m_count), 200'(target));
    endtask

    task automatic fill_seq();
        for (int i = 0; i < 25; i++) vals[i] = 8'(i + 1);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 25; i++) vals[i] = 8'($urandom);
    endtask

    // Asynchronous reset pulse between clock edges, checked before the next edge.
    task automatic async_reset();
        #3 rst_n = 1'b0;
        #1;
        m_count = 0; m_full = 0; m_valid = 0; m_rdy = 0;
        foreach (m_out[i, j]) m_out[i][j] = 8'sd0;
        check_outputs();
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0; hold_en = 0; hold_val = 200'd0;
        m_count = 0; m_full = 0; m_valid = 0; m_rdy = 0; m_mode = 0;
        foreach (m_out[i, j]) m_out[i][j] = 8'sd0;
        foreach (m_buf[i, j]) m_buf[i][j] = 8'sd0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'sd0; bus.in_col_major = 1'b0;
        bus.clear = 1'b0; bus.out_ready = 1'b0;

        // Reset state
        #12 check_outputs();
        @(posedge clk); #2 rst_n = 1'b1;

        // Row-major 1..25, in_valid held high, no acknowledge
        fill_seq();
        load_to(25, 1'b0, 1'b0, 1'b0);
        chk("rm_r0c0", 200'(bus.matrix_out[7:0]), 200'd1);
        chk("rm_r4c4", 200'(bus.matrix_out[199:192]), 200'd25);
        chk("rm_r1c0", 200'(bus.matrix_out[47:40]), 200'd6);
        chk("rm_ready", 200'(bus.in_ready), 200'd0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ack_in_ready", 200'(bus.in_ready), 200'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);

        // Column-major 1..25, order input wiggled after the first element
        fill_seq();
        load_to(25, 1'b0, 1'b1, 1'b1);
        chk("cm_r0c1", 200'(bus.matrix_out[15:8]), 200'd6);
        chk("cm_r1c0", 200'(bus.matrix_out[47:40]), 200'd2);
        chk("cm_r4c4", 200'(bus.matrix_out[199:192]), 200'd25);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Random in_valid with extreme values: matrix A
        fill_rand();
        vals[0] = -8'sd128; vals[12] = 8'sd127; vals[24] = -8'sd1;
        load_to(25, 1'b1, 1'b0, 1'b1);
        chk("ex_r0c0", 200'(bus.matrix_out[7:0]), 200'h80);
        chk("ex_r2c2", 200'(bus.matrix_out[103:96]), 200'h7F);
        chk("ex_r4c4", 200'(bus.matrix_out[199:192]), 200'hFF);
        for (int k = 0; k < 3; k++) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);

        // Acknowledge A, then load B while A must stay presented
        hold_val = flat();
        hold_en  = 1;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        fill_rand();
        load_to(25, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        hold_en = 0;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Clear after 12 elements with in_valid high, then a fresh load
        fill_rand();
        load_to(12, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("clr_count", 200'(bus.load_count), 200'd0);
        fill_rand();
        load_to(25, 1'b0, 1'b1, 1'b0);
        // Clear while FULL, together with out_ready
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        chk("clr_full_valid", 200'(bus.out_valid), 200'd0);

        // Reset mid-load, then reset in FULL, then a normal load
        fill_rand();
        load_to(7, 1'b0, 1'b0, 1'b0);
        async_reset();
        fill_rand();
        load_to(25, 1'b1, 1'b0, 1'b0);
        async_reset();
        fill_seq();
        load_to(25, 1'b0, 1'b0, 1'b0);
        chk("post_rst_r4c4", 200'(bus.matrix_out[199:192]), 200'd25);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
